basemul_seq: RTL

- Sequencer that drives base_case_mul for a full ML-KEM NTT-domain polynomial product (FIPS 203 Alg. 11, MultiplyNTTs).
- Reads 128 coefficient pairs from two polynomial RAMs and looks up gamma_i from an internal ROM.
- Issues one pair per cycle into the multiplier, collects c0/c1 on mul_valid_i and writes the results to a destination RAM.
- Sits between the polynomial memory banks and base_case_mul.

---
 rtl/poly_arith_pkg.sv | 24 ++
 rtl/basemul_gamma_rom.sv | 42 ++++
 rtl/basemul_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the ML-KEM polynomial arithmetic blocks.
package poly_arith_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned COEFF_W = 12;
  localparam int unsigned N_PAIRS = 128;
  localparam int unsigned IDX_W   = 7;

  typedef logic [COEFF_W-1:0] coeff_t;

  // Degree-one pair; c0 occupies the low bits when packed into a RAM word.
  typedef struct packed {
    coeff_t c1;
    coeff_t c0;
  } pair_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } bm_state_e;

endpackage

// File: rtl/basemul_gamma_rom.sv
// gamma_i = 17^(2*BitRev7(i)+1) mod q. Odd entries are the negation of the preceding even entry,
// so only the even half is tabulated.
module basemul_gamma_rom
  import poly_arith_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output coeff_t           gamma
);

  coeff_t g_even;

  always_comb begin
    g_even = '0;
    case (idx[IDX_W-1:1])
      6'd0:  g_even = 12'd17;    6'd1:  g_even = 12'd2761;  6'd2:  g_even = 12'd583;
      6'd3:  g_even = 12'd2649;  6'd4:  g_even = 12'd1637;  6'd5:  g_even = 12'd723;
      6'd6:  g_even = 12'd2288;  6'd7:  g_even = 12'd1100;  6'd8:  g_even = 12'd1409;
      6'd9:  g_even = 12'd2662;  6'd10: g_even = 12'd3281;  6'd11: g_even = 12'd233;
      6'd12: g_even = 12'd756;   6'd13: g_even = 12'd2156;  6'd14: g_even = 12'd3015;
      6'd15: g_even = 12'd3050;  6'd16: g_even = 12'd1703;  6'd17: g_even = 12'd1651;
      6'd18: g_even = 12'd2789;  6'd19: g_even = 12'd1789;  6'd20: g_even = 12'd1847;
      6'd21: g_even = 12'd952;   6'd22: g_even = 12'd1461;  6'd23: g_even = 12'd2687;
      6'd24: g_even = 12'd939;   6'd25: g_even = 12'd2308;  6'd26: g_even = 12'd2437;
      6'd27: g_even = 12'd2388;  6'd28: g_even = 12'd733;   6'd29: g_even = 12'd2337;
      6'd30: g_even = 12'd268;   6'd31: g_even = 12'd641;   6'd32: g_even = 12'd1584;
      6'd33: g_even = 12'd2298;  6'd34: g_even = 12'd2037;  6'd35: g_even = 12'd3220;
      6'd36: g_even = 12'd375;   6'd37: g_even = 12'd2549;  6'd38: g_even = 12'd2090;
      6'd39: g_even = 12'd1645;  6'd40: g_even = 12'd1063;  6'd41: g_even = 12'd319;
      6'd42: g_even = 12'd2773;  6'd43: g_even = 12'd757;   6'd44: g_even = 12'd2099;
      6'd45: g_even = 12'd561;   6'd46: g_even = 12'd2466;  6'd47: g_even = 12'd2594;
      6'd48: g_even = 12'd2804;  6'd49: g_even = 12'd1092;  6'd50: g_even = 12'd403;
      6'd51: g_even = 12'd1026;  6'd52: g_even = 12'd1143;  6'd53: g_even = 12'd2150;
      6'd54: g_even = 12'd2775;  6'd55: g_even = 12'd886;   6'd56: g_even = 12'd1722;
      6'd57: g_even = 12'd1212;  6'd58: g_even = 12'd1874;  6'd59: g_even = 12'd1029;
      6'd60: g_even = 12'd2110;  6'd61: g_even = 12'd2935;  6'd62: g_even = 12'd885;
      6'd63: g_even = 12'd2154;
      default: g_even = '0;
    endcase
    gamma = idx[0] ? coeff_t'(KYBER_Q) - g_even : g_even;
  end

endmodule

// File: rtl/basemul_seq.sv
// Sequences one full MultiplyNTTs pass: streams 128 pairs plus gamma into base_case_mul and
// writes the returned products to the destination RAM.
module basemul_seq
  import poly_arith_pkg::*;
#(
  parameter int unsigned N_PAIRS = 128,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             rd_en_o,
  output logic [IDX_W-1:0] rd_addr_o,
  input  logic [23:0]      a_rdata_i,
  input  logic [23:0]      b_rdata_i,
  output logic             mul_valid_o,
  output coeff_t           mul_a0_o,
  output coeff_t           mul_a1_o,
  output coeff_t           mul_b0_o,
  output coeff_t           mul_b1_o,
  output coeff_t           mul_zeta_o,
  input  logic             mul_valid_i,
  input  coeff_t           mul_c0_i,
  input  coeff_t           mul_c1_i,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_addr_o,
  output logic [23:0]      wr_data_o
);

  localparam int unsigned      TO_LIMIT = MUL_LAT + RD_LAT + 4;
  localparam int unsigned      TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PAIRS - 1);

  bm_state_e        state_q, state_d;
  logic [IDX_W-1:0] iss_cnt_q, res_cnt_q;
  logic             res_full_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             err_q;
  logic [RD_LAT-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [RD_LAT];
  pair_t            a_hold_q, b_hold_q;
  coeff_t           zeta_hold_q;
  logic             wr_en_q;
  logic [IDX_W-1:0] wr_addr_q;
  logic [23:0]      wr_data_q;

  logic   start_ok, active, wr_ok, proto_err, timeout, rd_vld;
  coeff_t rom_gamma;
  pair_t  a_pair, b_pair;

  assign start_ok  = (state_q == StIdle) && start_i;
  assign active    = (state_q == StRun) || (state_q == StDrain);
  assign wr_ok     = mul_valid_i && active && !res_full_q;
  // Results outside a run, or beyond the last pair, are protocol violations and are dropped.
  assign proto_err = mul_valid_i && !wr_ok;
  assign timeout   = (state_q == StDrain) && !res_full_q && !mul_valid_i &&
                     (to_cnt_q == TO_W'(TO_LIMIT - 1));
  assign rd_vld    = vld_q[RD_LAT-1];
  assign a_pair    = pair_t'(a_rdata_i);
  assign b_pair    = pair_t'(b_rdata_i);

  basemul_gamma_rom u_gamma_rom (
    .idx   (idx_q[RD_LAT-1]),
    .gamma (rom_gamma)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (iss_cnt_q == LAST_IDX) state_d = StDrain;
      StDrain: if (res_full_q || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
    err_o       = err_q;
    rd_en_o     = (state_q == StRun);
    rd_addr_o   = rd_en_o ? iss_cnt_q : '0;
    // Operands pass straight from the RAM while valid, otherwise replay the last issued pair.
    mul_valid_o = rd_vld;
    mul_a0_o    = rd_vld ? a_pair.c0 : a_hold_q.c0;
    mul_a1_o    = rd_vld ? a_pair.c1 : a_hold_q.c1;
    mul_b0_o    = rd_vld ? b_pair.c0 : b_hold_q.c0;
    mul_b1_o    = rd_vld ? b_pair.c1 : b_hold_q.c1;
    mul_zeta_o  = rd_vld ? rom_gamma : zeta_hold_q;
    wr_en_o     = wr_en_q;
    wr_addr_o   = wr_addr_q;
    wr_data_o   = wr_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      iss_cnt_q   <= '0;
      res_cnt_q   <= '0;
      res_full_q  <= 1'b0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      vld_q       <= '0;
      for (int k = 0; k < int'(RD_LAT); k++) idx_q[k] <= '0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
      zeta_hold_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        iss_cnt_q  <= '0;
        res_cnt_q  <= '0;
        res_full_q <= 1'b0;
      end else begin
        if (rd_en_o && (iss_cnt_q != LAST_IDX)) iss_cnt_q <= iss_cnt_q + 1'b1;
        // The result counter saturates on its terminal flag instead of wrapping.
        if (wr_ok) begin
          if (res_cnt_q == LAST_IDX) res_full_q <= 1'b1;
          else                       res_cnt_q  <= res_cnt_q + 1'b1;
        end
      end

      if (mul_valid_i || !active)           to_cnt_q <= '0;
      else if (to_cnt_q != TO_W'(TO_LIMIT)) to_cnt_q <= to_cnt_q + 1'b1;

      if (proto_err || timeout) err_q <= 1'b1;
      else if (start_ok)        err_q <= 1'b0;

      vld_q[0] <= rd_en_o;
      idx_q[0] <= rd_addr_o;
      for (int k = 1; k < int'(RD_LAT); k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end

      if (rd_vld) begin
        a_hold_q    <= a_pair;
        b_hold_q    <= b_pair;
        zeta_hold_q <= rom_gamma;
      end

      wr_en_q <= wr_ok;
      if (wr_ok) begin
        wr_addr_q <= res_cnt_q;
        wr_data_q <= {mul_c1_i, mul_c0_i};
      end
    end
  end

endmodule
